// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM serializer/deserializer pair.
package tdm_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } tdm_state_t;

    localparam int TDM_LANES = 8;

    // Slot index width; also used by the transmit-side select counter.
    function automatic int slot_width(input int lanes);
        return $clog2(lanes);
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Mod-LANES slot counter with clear, load-to-1 and increment (priority in that order).
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int LANES  = TDM_LANES,
    parameter int SLOT_W = slot_width(LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= SLOT_W'(1);
        end else if (inc) begin
            cnt <= (cnt == SLOT_W'(LANES - 1)) ? '0 : cnt + SLOT_W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux18.sv
// TDM 1:LANES deserializer with sync-marker frame alignment and error flagging.
module tdm_demux18
    import tdm_pkg::*;
#(
    parameter int LANES  = TDM_LANES,
    parameter int SLOT_W = slot_width(LANES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              en,
    input  logic              sync,
    output logic [LANES-1:0]  dout,
    output logic              out_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              frame_err
);

    tdm_state_t        state_q, state_d;
    logic [LANES-2:0]  shadow;
    logic              ctr_clr, ctr_load1, ctr_inc;
    logic              sh_we, sh_zero;
    logic              dout_ld, valid_d, err_d;

    tdm_slot_ctr #(.LANES(LANES), .SLOT_W(SLOT_W)) u_ctr (
        .clk   (clk),
        .rst   (rst),
        .clr   (ctr_clr),
        .load1 (ctr_load1),
        .inc   (ctr_inc),
        .cnt   (slot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HUNT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ctr_clr   = 1'b0;
        ctr_load1 = 1'b0;
        ctr_inc   = 1'b0;
        sh_we     = 1'b0;
        sh_zero   = 1'b0;
        dout_ld   = 1'b0;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        if (en) begin
            unique case (state_q)
                HUNT: begin
                    if (sync) begin
                        sh_we     = 1'b1;
                        sh_zero   = 1'b1;
                        ctr_load1 = 1'b1;
                        state_d   = LOCKED;
                    end
                end
                LOCKED: begin
                    if (sync) begin
                        // An early marker restarts the frame on this bit.
                        err_d     = (slot != '0);
                        sh_we     = 1'b1;
                        sh_zero   = 1'b1;
                        ctr_load1 = 1'b1;
                    end else if (slot == '0) begin
                        err_d   = 1'b1;
                        ctr_clr = 1'b1;
                        state_d = HUNT;
                    end else if (slot == SLOT_W'(LANES - 1)) begin
                        dout_ld = 1'b1;
                        valid_d = 1'b1;
                        ctr_inc = 1'b1;
                    end else begin
                        sh_we   = 1'b1;
                        ctr_inc = 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Last slot bit bypasses the shadow straight into the MSB of dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            dout      <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (sh_we) begin
                shadow[sh_zero ? '0 : slot] <= din;
            end
            if (dout_ld) begin
                dout <= {din, shadow};
            end
            out_valid <= valid_d;
            frame_err <= err_d;
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_tdm_demux18.sv
// Directed self-checking bench for tdm_demux18 with LANES=8.
module tb_tdm_demux18;

    logic       clk;
    logic       rst;
    logic       din;
    logic       en;
    logic       sync;
    logic [7:0] dout;
    logic       out_valid;
    logic [2:0] slot;
    logic       locked;
    logic       frame_err;

    int checks = 0;
    int errors = 0;

    tdm_demux18 #(.LANES(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .en        (en),
        .sync      (sync),
        .dout      (dout),
        .out_valid (out_valid),
        .slot      (slot),
        .locked    (locked),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one strobed bit, then land 1 time unit after the sampling edge.
    task automatic send_bit(input logic d, input logic s);
        en   = 1'b1;
        din  = d;
        sync = s;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        en   = 1'b0;
        sync = 1'b0;
        din  = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [7:0] v, input bit err_first, input bit gapped);
        for (int i = 0; i < 8; i++) begin
            send_bit(v[i], i == 0);
            check("frame_err", frame_err, (i == 0) && err_first);
            check("out_valid", out_valid, i == 7);
            check("slot", slot, (i + 1) % 8);
            check("locked", locked, 1);
            if (gapped && i < 7) idle(i % 4);
        end
        check("dout", dout, v);
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        din  = 1'b0;
        sync = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dout", dout, 0);
        check("rst_valid", out_valid, 0);
        check("rst_slot", slot, 0);
        check("rst_locked", locked, 0);
        check("rst_err", frame_err, 0);
        rst = 1'b0;
        idle(1);

        // Bits without a marker are dropped while hunting
        for (int i = 0; i < 5; i++) begin
            send_bit(1'b1, 1'b0);
            check("hunt_locked", locked, 0);
            check("hunt_slot", slot, 0);
            check("hunt_err", frame_err, 0);
            check("hunt_valid", out_valid, 0);
        end
        frame(8'h81, 1'b0, 1'b0);
        idle(1);
        check("81_valid_drop", out_valid, 0);

        frame(8'hA5, 1'b0, 1'b0);
        idle(1);
        check("a5_valid_drop", out_valid, 0);
        check("a5_hold", dout, 8'hA5);

        // Back-to-back frames, en held high throughout
        frame(8'h3C, 1'b0, 1'b0);
        frame(8'hFF, 1'b0, 1'b0);
        idle(2);
        check("ff_hold", dout, 8'hFF);

        // Early sync after 3 bits
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("partial_slot", slot, 3);
        frame(8'h0F, 1'b1, 1'b0);
        idle(1);

        // Missing sync on the next slot-0 bit
        frame(8'h55, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("miss_err", frame_err, 1);
        check("miss_locked", locked, 0);
        check("miss_slot", slot, 0);
        check("miss_valid", out_valid, 0);
        check("miss_dout", dout, 8'h55);
        idle(1);
        check("miss_err_drop", frame_err, 0);

        // Gapped strobes
        idle(2);
        frame(8'hC3, 1'b0, 1'b1);
        idle(3);
        check("c3_hold", dout, 8'hC3);
        check("c3_valid_drop", out_valid, 0);

        // Reset in mid-frame
        send_bit(1'b0, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("pre_rst_slot", slot, 4);
        en = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_dout", dout, 0);
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_slot", slot, 0);
        check("mid_rst_locked", locked, 0);
        check("mid_rst_err", frame_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_locked", locked, 0);
        check("post_rst_dout", dout, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tdm_demux18.md
# tdm_demux18

Receive-side counterpart of the 8:1 select-mux serializer. It takes the single-bit time-division stream the mux produces when its select lines are stepped 0..7, and redistributes each bit to its lane: bit for select value k lands in output lane k. The block tracks frame alignment with a sync marker, assembles complete frames into a parallel word and flags misaligned frames. It sits between the serial link and the parallel lane consumers, such as the visitor-counter sensor lanes.

## Interface
- LANES, 8, number of TDM slots per frame; power of two, 2..16
- SLOT_W, $clog2(LANES), slot index width; derived, do not override
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- din  in  1  serial data bit, qualified by en
- en  in  1  bit strobe; din/sync sampled only when en=1
- sync  in  1  frame marker; high with the slot-0 bit of every frame
- dout  out  LANES  assembled frame; bit k = slot k
- out_valid  out  1  one-cycle pulse, dout updated this cycle
- slot  out  SLOT_W  slot index expected for the next en bit
- locked  out  1  high while frame alignment is held
- frame_err  out  1  one-cycle pulse on an alignment violation

## Operation
- State machine with two states, HUNT and LOCKED. Reset state is HUNT.
- Reset values: dout=0, out_valid=0, slot=0, locked=0, frame_err=0. The shadow register is also cleared to 0.
- HUNT:
  - Bits with en=1 and sync=0 are discarded.
  - en=1 with sync=1 writes din to shadow[0], sets slot=1 and moves to LOCKED.
- LOCKED, per en=1 bit:
  - slot≠0 and sync=0: shadow[slot]=din, then slot increments.
  - slot=LANES-1 and sync=0:
    - dout takes shadow[LANES-2:0] with din placed at the MSB.
    - out_valid pulses.
    - slot wraps to 0 and the state stays LOCKED.
  - slot=0 and sync=1: shadow[0]=din and slot=1. This is a normal frame start.
  - slot=0 and sync=0 (missing marker):
    - frame_err pulses, state goes to HUNT, slot=0.
    - The bit is discarded.
  - slot≠0 and sync=1 (early marker):
    - frame_err pulses and the partial frame is discarded; dout is unchanged.
    - The bit is taken as the slot-0 bit of a new frame: shadow[0]=din, slot=1, state stays LOCKED.
- en=0: no state change and no pulses. Gaps of any length between strobes are legal.
- locked = (state == LOCKED).
- dout holds its value between frames. Shadow bits from an abandoned frame are never exposed on dout.

## Timing
- All outputs are registered.
- Latency is one cycle: the slot-(LANES-1) bit sampled at edge N produces the new dout with out_valid=1 after edge N. out_valid drops after edge N+1 unless another frame completes.
- en may be high every cycle. Back-to-back frames give one out_valid every LANES cycles.
- out_valid and frame_err are never high in the same cycle.
- Reset is asserted asynchronously and released synchronously by the system. Reset in mid-frame drops the partial frame, and no out_valid is produced.

## Structure
- Package tdm_pkg holds:
  - the state enum (HUNT, LOCKED)
  - the default TDM_LANES=8
  - a slot-width function shared with the transmit-side select counter
- Sub-module tdm_slot_ctr is the natural split. It is a mod-LANES counter with inc, load-to-1 and clear inputs, and it is reused by the mux-side select sequencer.
- The FSM, shadow register and output registers stay in the top module.

## Test plan
- Reset, then an aligned frame with LANES=8: send the bits of 8'hA5 LSB first on 8 consecutive en cycles, sync high on the first.
  - Response: dout=8'hA5 and out_valid high for exactly one cycle, one cycle after the 8th bit.
  - locked=1 from the cycle after the first bit.
- Back-to-back frames 8'h3C then 8'hFF with en held high.
  - Response: two out_valid pulses 8 cycles apart, dout=8'h3C then 8'hFF, frame_err never pulses.
- HUNT discard: before any sync, send 5 bits with en=1 and sync=0, then frame 8'h81.
  - Response: locked stays 0 through the 5 bits, then dout=8'h81. No frame_err.
- Early sync: after 3 bits of a frame, assert sync and send frame 8'h0F.
  - Response: frame_err pulses on the sync cycle, with no out_valid for the partial frame.
  - Then dout=8'h0F.
- Missing sync: after a good frame 8'h55, send the next slot-0 bit with sync=0.
  - Response: frame_err pulses, locked drops to 0 and slot=0. dout stays 8'h55.
- Gapped strobes and reset mid-frame:
  - Frame 8'hC3 sent with en=0 gaps of 0–3 cycles between bits: dout=8'hC3.
  - Then assert rst after 4 bits of the next frame: all outputs return to their reset values, with no out_valid.
